// File: rtl/vector_compare_sequencer.sv
// Breaks a masked vector compare over an LMUL register group into one beat per cycle,
// tracks the in-flight beats of the compare datapath and assembles the packed result mask.
module vector_compare_sequencer #(
    parameter int VLEN        = 128,
    parameter int CMP_LATENCY = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_op,
    input  logic [1:0]               req_sew,
    input  logic [1:0]               req_lmul,
    input  logic [$clog2(VLEN):0]    req_vl,
    output logic [2:0]               src_index,
    input  logic [VLEN-1:0]          src_vs2,
    input  logic [VLEN-1:0]          src_vs1,
    output logic [3:0]               cmp_op,
    output logic [1:0]               cmp_sew,
    output logic [VLEN-1:0]          cmp_vs2,
    output logic [VLEN-1:0]          cmp_vs1,
    input  logic [VLEN-1:0]          cmp_vd,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [VLEN-1:0]          rsp_mask,
    output logic                     busy,
    output logic [1:0]               fsm_state
);

    localparam int LOG2_VLEN = $clog2(VLEN);
    localparam int VL_W      = LOG2_VLEN + 1;
    localparam int SH_W      = $clog2(LOG2_VLEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [3:0]           op_q;
    logic [1:0]           sew_q;
    logic [SH_W-1:0]      sh_q;
    logic [VL_W-1:0]      vl_q;
    logic [2:0]           last_q;
    logic [2:0]           issue_k;
    logic [CMP_LATENCY-1:0] pipe_vld;
    logic [2:0]           pipe_idx [CMP_LATENCY];

    logic [SH_W-1:0]      acc_sh;
    logic [VL_W-1:0]      acc_vlmax;
    logic [VL_W-1:0]      acc_vl;
    logic [VL_W:0]        acc_e_m1;
    logic [VL_W:0]        acc_round;
    logic [3:0]           acc_beats;

    logic                 cap_valid;
    logic [2:0]           cap_idx;
    logic [VLEN-1:0]      mask_next;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds valid and payload stable until that edge, and ready never depends on valid.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    assign src_index = (state == ISSUE) ? issue_k : 3'd0;
    assign cmp_vs2   = (state == ISSUE) ? src_vs2 : '0;
    assign cmp_vs1   = (state == ISSUE) ? src_vs1 : '0;
    assign cmp_op    = op_q;
    assign cmp_sew   = sew_q;

    // sh is log2 of elements per beat, so E = 1 << sh and VLMAX = 1 << (sh + lmul).
    always_comb begin
        acc_sh    = SH_W'(LOG2_VLEN - 3) - SH_W'(req_sew);
        acc_vlmax = VL_W'(1) << (acc_sh + SH_W'(req_lmul));
        acc_vl    = (req_vl > acc_vlmax) ? acc_vlmax : req_vl;
        acc_e_m1  = ((VL_W+1)'(1) << acc_sh) - (VL_W+1)'(1);
        acc_round = {1'b0, acc_vl} + acc_e_m1;
        acc_beats = 4'(acc_round >> acc_sh);
    end

    assign cap_valid = pipe_vld[CMP_LATENCY-1];
    assign cap_idx   = pipe_idx[CMP_LATENCY-1];

    // Merge the captured beat into the mask; element i lives in beat i>>sh at lane i&(E-1).
    always_comb begin
        logic [LOG2_VLEN-1:0] pos;
        logic [LOG2_VLEN-1:0] lane_mask;
        mask_next = rsp_mask;
        lane_mask = (LOG2_VLEN'(1) << sh_q) - LOG2_VLEN'(1);
        for (int i = 0; i < VLEN; i++) begin
            pos = LOG2_VLEN'(i);
            if (cap_valid && ((pos >> sh_q) == LOG2_VLEN'(cap_idx))) begin
                mask_next[i] = cmp_vd[pos & lane_mask] & (VL_W'(i) < vl_q);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= '0;
            sew_q     <= '0;
            sh_q      <= '0;
            vl_q      <= '0;
            last_q    <= '0;
            issue_k   <= '0;
            pipe_vld  <= '0;
            for (int j = 0; j < CMP_LATENCY; j++) begin
                pipe_idx[j] <= '0;
            end
            rsp_mask  <= '0;
            rsp_valid <= 1'b0;
        end else begin
            pipe_vld[0] <= (state == ISSUE);
            pipe_idx[0] <= issue_k;
            for (int j = 1; j < CMP_LATENCY; j++) begin
                pipe_vld[j] <= pipe_vld[j-1];
                pipe_idx[j] <= pipe_idx[j-1];
            end
            rsp_mask <= mask_next;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        sew_q    <= req_sew;
                        sh_q     <= acc_sh;
                        vl_q     <= acc_vl;
                        last_q   <= 3'(acc_beats - 4'd1);
                        issue_k  <= '0;
                        rsp_mask <= '0;
                        if (acc_vl == '0) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_k == last_q) begin
                        state <= DRAIN;
                    end else begin
                        issue_k <= issue_k + 3'd1;
                    end
                end
                DRAIN: begin
                    // The last beat always lands here, since it is issued as ISSUE ends.
                    if (cap_valid && (cap_idx == last_q)) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_compare_sequencer.sv
// Bench for vector_compare_sequencer: models the compare datapath and register file, scoreboards
// each response mask and its latency against a per-element reference model.
module tb_vector_compare_sequencer;

    localparam int VLEN = 128;
    localparam int L    = 2;
    localparam int VL_W = $clog2(VLEN) + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_op = '0;
    logic [1:0]        req_sew = '0;
    logic [1:0]        req_lmul = '0;
    logic [VL_W-1:0]   req_vl = '0;
    logic [2:0]        src_index;
    logic [VLEN-1:0]   src_vs2, src_vs1;
    logic [3:0]        cmp_op;
    logic [1:0]        cmp_sew;
    logic [VLEN-1:0]   cmp_vs2, cmp_vs1, cmp_vd;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [VLEN-1:0]   rsp_mask;
    logic              busy;
    logic [1:0]        fsm_state;

    vector_compare_sequencer #(.VLEN(VLEN), .CMP_LATENCY(L)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_sew(req_sew), .req_lmul(req_lmul), .req_vl(req_vl),
        .src_index(src_index), .src_vs2(src_vs2), .src_vs1(src_vs1),
        .cmp_op(cmp_op), .cmp_sew(cmp_sew), .cmp_vs2(cmp_vs2), .cmp_vs1(cmp_vs1),
        .cmp_vd(cmp_vd), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_mask(rsp_mask), .busy(busy), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset / environment ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    logic [VLEN-1:0] reg2 [8];
    logic [VLEN-1:0] reg1 [8];
    logic [VLEN-1:0] pre2 [8];
    logic [VLEN-1:0] pre1 [8];
    assign src_vs2 = reg2[src_index];
    assign src_vs1 = reg1[src_index];

    function automatic logic [VLEN-1:0] cmp_fn(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                              input logic [3:0] op);
        return ~(a ^ b) ^ {(VLEN/4){op}};
    endfunction

    // Compare unit with fixed latency; idle cycles yield mostly-ones junk.
    logic [VLEN-1:0] dp [L];
    always @(posedge clock) begin
        dp[0] <= cmp_fn(cmp_vs2, cmp_vs1, cmp_op);
        for (int j = 1; j < L; j++) dp[j] <= dp[j-1];
    end
    assign cmp_vd = dp[L-1];

    function automatic logic [VLEN-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- reference model ----------------
    function automatic int eff_vl(input int sew, input int lmul, input int vl);
        int e = VLEN / (8 << sew);
        int vlmax = e * (1 << lmul);
        return (vl > vlmax) ? vlmax : vl;
    endfunction

    function automatic logic [VLEN-1:0] model_mask(input logic [3:0] op, input int sew, input int n);
        int e = VLEN / (8 << sew);
        logic [VLEN-1:0] m = '0;
        logic [VLEN-1:0] r;
        for (int i = 0; i < n; i++) begin
            r = cmp_fn(reg2[i / e], reg1[i / e], op);
            m[i] = r[i % e];
        end
        return m;
    endfunction

    function automatic int model_latency(input int sew, input int n);
        int e = VLEN / (8 << sew);
        return (n == 0) ? 1 : ((n + e - 1) / e) + L + 1;
    endfunction

    // ---------------- scoreboard ----------------
    logic [VLEN-1:0] exp_q[$];
    int lat_q[$];
    int acc_q[$];
    int total = 0;
    int bad = 0;
    int ready_mode = 0;

    task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [3:0] op, input int sew, input int lmul, input int vl,
                            input bit rnd, input bit push);
        int w = 0;
        int n;
        @(negedge clock);
        while (!req_ready && w < 300) begin
            @(negedge clock);
            w++;
        end
        if (!req_ready) begin
            check("req_ready_wait", req_ready, 1);
            return;
        end
        for (int k = 0; k < 8; k++) begin
            reg2[k] = rnd ? rand128() : pre2[k];
            reg1[k] = rnd ? rand128() : pre1[k];
        end
        req_op    = op;
        req_sew   = 2'(sew);
        req_lmul  = 2'(lmul);
        req_vl    = VL_W'(vl);
        req_valid = 1'b1;
        if (push) begin
            n = eff_vl(sew, lmul, vl);
            exp_q.push_back(model_mask(op, sew, n));
            lat_q.push_back(model_latency(sew, n));
            acc_q.push_back(cyc);
        end
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        req_op    = 4'($urandom_range(0, 15));
        req_vl    = VL_W'($urandom_range(0, VLEN));
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((exp_q.size() != 0 || !req_ready) && w < 600) begin
            @(negedge clock);
            w++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    bit prev_valid = 0;
    bit after_hs = 0;
    logic [VLEN-1:0] held_mask;
    logic [1:0] held_state;
    int lat_e, acc_c;

    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 0;
            after_hs   = 0;
            rsp_ready  = 1'b0;
        end else begin
            if (after_hs) begin
                check("idle_after_hs", {rsp_valid, req_ready}, 2'b01);
                after_hs = 0;
            end
            if (rsp_valid) begin
                if (!prev_valid) begin
                    if (lat_q.size() == 0) begin
                        check("unexpected_rsp", rsp_valid, 0);
                    end else begin
                        lat_e = lat_q.pop_front();
                        acc_c = acc_q.pop_front();
                        check("latency", cyc - acc_c, lat_e);
                    end
                    held_mask  = rsp_mask;
                    held_state = fsm_state;
                end else begin
                    check("mask_stable", rsp_mask, held_mask);
                    check("state_stable", fsm_state, held_state);
                end
                check("done_ready_busy", {req_ready, busy}, 2'b01);
                case (ready_mode)
                    1: rsp_ready = 1'b0;
                    2: rsp_ready = 1'b1;
                    default: rsp_ready = ($urandom_range(0, 2) != 0);
                endcase
                if (rsp_ready) begin
                    if (exp_q.size() == 0) check("unexpected_hs", rsp_valid, 0);
                    else check("rsp_mask", rsp_mask, exp_q.pop_front());
                    after_hs   = 1;
                    prev_valid = 0;
                end else begin
                    prev_valid = 1;
                end
            end else begin
                prev_valid = 0;
                rsp_ready  = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int w;
        repeat (3) @(negedge clock);
        check("rst_outputs", {rsp_valid, busy, req_ready, src_index}, {1'b0, 1'b0, 1'b1, 3'd0});
        check("rst_mask", rsp_mask, '0);
        check("rst_cmp_vs2", cmp_vs2, '0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", req_ready, 1);

        // SEW=8 LMUL=1 vl=16 with result pattern A5A5
        for (int k = 0; k < 8; k++) begin
            pre2[k] = rand128();
            pre1[k] = rand128();
        end
        pre2[0] = ~(128'hA5A5);
        pre1[0] = '0;
        send_req(4'd0, 0, 0, 16, 1'b0, 1'b1);

        // SEW=32 LMUL=4 vl=10, all-ones results, beats on consecutive cycles
        wait_drain();
        for (int k = 0; k < 8; k++) begin
            pre2[k] = rand128();
            pre1[k] = pre2[k];
        end
        send_req(4'd0, 2, 2, 10, 1'b0, 1'b1);
        check("issue_beat0", {cmp_sew, src_index}, {2'd2, 3'd0});
        @(negedge clock);
        check("issue_beat1", src_index, 1);
        @(negedge clock);
        check("issue_beat2", src_index, 2);
        @(negedge clock);
        check("drain_index", src_index, 0);
        check("drain_vs2", cmp_vs2, '0);

        // SEW=64 LMUL=1 req_vl=5 clamps to 2
        send_req(4'd0, 3, 0, 5, 1'b0, 1'b1);

        // vl=0
        send_req(4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), 0, 1'b1, 1'b1);

        // response held off for 10 cycles in DONE
        wait_drain();
        ready_mode = 1;
        send_req(4'($urandom_range(0, 15)), 1, 1, $urandom_range(1, 16), 1'b1, 1'b1);
        n = 0;
        w = 0;
        while (n < 10 && w < 200) begin
            @(negedge clock);
            if (rsp_valid) n++;
            w++;
        end
        check("held_cycles", n, 10);
        ready_mode = 2;
        wait_drain();
        ready_mode = 0;

        // reset in cycle 2 of an LMUL=8 request
        send_req(4'($urandom_range(0, 15)), 0, 3, VLEN, 1'b1, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_outputs", {rsp_valid, busy, req_ready, src_index}, {1'b0, 1'b0, 1'b1, 3'd0});
        check("abort_mask", rsp_mask, '0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_abort", req_ready, 1);
        repeat (12) @(negedge clock);
        send_req(4'($urandom_range(0, 15)), 0, 3, VLEN, 1'b1, 1'b1);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            send_req(4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, VLEN), 1'b1, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        wait_drain();
        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        total++;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_compare_sequencer.md
VECTOR_COMPARE_SEQUENCER -- requirements
Module: vector_compare_sequencer

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector register width in bits.
REQ-002 SHALL have parameter CMP_LATENCY, default 2, cycles from cmp_vs2/cmp_vs1 drive to cmp_vd valid.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  compare request present.
REQ-006 SHALL have port req_ready  output  1  sequencer can accept a request.
REQ-007 SHALL have port req_op  input  4  compare function code, forwarded unchanged to cmp_op.
REQ-008 SHALL have port req_sew  input  2  element width: 0=8, 1=16, 2=32, 3=64 bits.
REQ-009 SHALL have port req_lmul  input  2  register group size: 0=1, 1=2, 2=4, 3=8.
REQ-010 SHALL have port req_vl  input  $clog2(VLEN)+1  active element count.
REQ-011 SHALL have port src_index  output  3  register offset within group for current beat.
REQ-012 SHALL have port src_vs2, src_vs1  input  VLEN  operands for src_index, valid in the same cycle.
REQ-013 SHALL have port cmp_op  output  4, cmp_sew  output  2, cmp_vs2  output  VLEN, cmp_vs1  output  VLEN  comparison datapath drive.
REQ-014 SHALL have port cmp_vd  input  VLEN  comparison result; mask bits in LSBs.
REQ-015 SHALL have port rsp_valid  output  1, rsp_ready  input  1, rsp_mask  output  VLEN  result handshake.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement states IDLE, ISSUE, DRAIN, DONE; req_ready high only in IDLE.
REQ-018 SHALL latch op, sew, vl on req_valid && req_ready; E = VLEN/SEW elements per beat; VLMAX = LMUL*E.
REQ-019 SHALL clamp latched vl to VLMAX when req_vl > VLMAX.
REQ-020 SHALL compute beat count N = ceil(vl/E); vl=0 transitions IDLE->DONE with rsp_mask = 0.
REQ-021 SHALL, in ISSUE, issue one beat per cycle k = 0..N-1: src_index = k, cmp_vs2/cmp_vs1 = src_vs2/src_vs1 combinationally, cmp_op/cmp_sew = latched values.
REQ-022 SHALL move ISSUE->DRAIN after beat N-1; DRAIN->DONE in the cycle after the last beat is captured.
REQ-023 SHALL track in-flight beats with a CMP_LATENCY-deep valid/index shift register; no reliance on cmp_vd outside tracked cycles.
REQ-024 SHALL capture beat k from cmp_vd in cycle (issue cycle of k) + CMP_LATENCY: rsp_mask[k*E +: E] <= cmp_vd[E-1:0].
REQ-025 SHALL force rsp_mask bits at index >= vl to 0, including bits of the final partial beat.
REQ-026 SHALL clear rsp_mask to 0 on request acceptance.
REQ-027 SHALL hold rsp_valid high and rsp_mask stable in DONE until rsp_ready; DONE->IDLE on rsp_valid && rsp_ready.
REQ-028 SHALL give latency (accept edge = cycle 0): rsp_valid first high in cycle N + CMP_LATENCY + 1; vl=0 -> cycle 1.
REQ-029 SHALL not accept a new request in the cycle rsp handshake completes; next acceptance earliest one cycle later.
REQ-030 SHALL drive src_index = 0 and cmp_vs2 = cmp_vs1 = 0 when not in ISSUE.

Reset
REQ-031 SHALL, on reset high at an edge, enter IDLE; rsp_valid=0, busy=0, rsp_mask=0, src_index=0, valid shift register cleared, latched fields 0.
REQ-032 SHALL, on reset mid-operation, abandon the request; in-flight cmp_vd results are ignored and never reach rsp_mask.
REQ-033 SHALL assert req_ready in the first cycle after reset deasserts.

Verification
REQ-034 SEW=8, LMUL=1, vl=16, cmp_vd=16'hA5A5 -> rsp_valid in cycle 4, rsp_mask=16'hA5A5, upper bits 0.
REQ-035 SEW=32, LMUL=4, vl=10, cmp_vd all-ones each beat -> src_index 0,1,2 on consecutive cycles, rsp_valid in cycle 6, rsp_mask=10'h3FF.
REQ-036 vl=0, any config -> rsp_valid in cycle 1, rsp_mask=0, no ISSUE cycles.
REQ-037 SEW=64, LMUL=1, req_vl=5 -> vl clamped to 2, one beat, rsp_mask=2'b11 for cmp_vd all-ones.
REQ-038 rsp_ready held low 10 cycles in DONE -> rsp_mask stable, req_ready low; release -> IDLE next cycle.
REQ-039 reset asserted in cycle 2 of an LMUL=8 request -> IDLE, rsp_valid never asserted, next request result unaffected.
